iob_split_reg: RTL

- Parametrised successor of the native-bus split used in the SoC top level.
- Routes one native master bus to N_SLAVES slave buses, selected by an address bit field.
- Adds a registered request stage, tracking of the one outstanding transaction, a decode-error response for unmapped indices, and an optional slave watchdog.
- Used for the data-bus and peripheral-bus splits in the next-generation system.

---
 rtl/iob_split_reg.sv | 129 ++++++++++++
 1 files changed

// File: rtl/iob_split_reg.sv
// Native-bus split: one master routed to N_SLAVES slaves by an address bit field, with a
// registered request stage and decode-error response. Define SPLIT_TIMEOUT_EN for a slave watchdog.
module iob_split_reg #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                N_SLAVES       = 3,
  parameter int                P_SLAVES       = ADDR_W - 1,
  parameter int                NB             = ($clog2(N_SLAVES) > 0 ? $clog2(N_SLAVES) : 1),
  parameter logic [DATA_W-1:0] ERR_RDATA      = 32'hDEAD_BEEF,
  parameter int                TIMEOUT_CYCLES = 16,
  localparam int               STRB_W         = DATA_W / 8,
  localparam int               REQ_W          = 1 + ADDR_W + DATA_W + STRB_W,
  localparam int               RESP_W         = DATA_W + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REQ_W-1:0]             m_req,
  output logic [RESP_W-1:0]            m_resp,
  output logic [N_SLAVES*REQ_W-1:0]    s_req,
  input  logic [N_SLAVES*RESP_W-1:0]   s_resp,
  output logic                         busy,
  output logic                         err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic              m_valid;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [STRB_W-1:0] m_wstrb;
  logic [NB-1:0]     sel;
  logic              sel_ok;

  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [STRB_W-1:0] wstrb_r;
  logic [NB-1:0]     sel_r;

  logic [RESP_W-1:0] sel_resp;
  logic              sel_ready;
  logic              timeout_hit;

  assign {m_valid, m_addr, m_wdata, m_wstrb} = m_req;
  assign sel    = m_addr[P_SLAVES -: NB];
  assign sel_ok = 32'(sel) < N_SLAVES;

  // Only the registered slave's response is looked at; the others cannot complete a transfer.
  always_comb begin
    sel_resp = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (sel_r == NB'(k)) sel_resp = s_resp[k*RESP_W +: RESP_W];
    end
  end

  assign sel_ready = sel_resp[0];

`ifdef SPLIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] wd_cnt;

  // Held at zero outside WAIT so every transfer starts a fresh count.
  always_ff @(posedge clk) begin
    if (rst || state != WAIT) wd_cnt <= '0;
    else                      wd_cnt <= wd_cnt + CNT_W'(1);
  end

  assign timeout_hit = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_r  <= '0;
      wdata_r <= '0;
      wstrb_r <= '0;
      sel_r   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && m_valid && sel_ok) begin
        addr_r  <= m_addr;
        wdata_r <= m_wdata;
        wstrb_r <= m_wstrb;
        sel_r   <= sel;
      end
    end
  end

  // A slave ready in the expiry cycle takes priority over the watchdog.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (m_valid) state_nxt = sel_ok ? WAIT : ERR;
      WAIT: begin
        if (sel_ready)        state_nxt = IDLE;
        else if (timeout_hit) state_nxt = ERR;
      end
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_req  = '0;
    m_resp = '0;
    case (state)
      WAIT: begin
        for (int k = 0; k < N_SLAVES; k++) begin
          if (sel_r == NB'(k)) s_req[k*REQ_W +: REQ_W] = {1'b1, addr_r, wdata_r, wstrb_r};
        end
        m_resp = sel_resp;
      end
      ERR:     m_resp = {ERR_RDATA, 1'b1};
      default: m_resp = '0;
    endcase
  end

  assign busy = (state != IDLE);
  assign err  = (state == ERR);

endmodule
